// File: rtl/bitonic_network_pkg.sv
// Shared definitions for the bitonic sorting network.
// Holds the stage-count arithmetic used to size the pipeline, the default
// network geometry, and a key type for the default key width.
package bitonic_network_pkg;

    // log2 of a power-of-two key count (the number of merge phases, L).
    function automatic int log2_int(input int n);
        int r;
        r = 0;
        for (int b = 0; b < 31; b++) begin
            if ((1 << b) < n) r = b + 1;
        end
        return r;
    endfunction

    // Compare-exchange stages in a full bitonic sort: 1 + 2 + ... + L.
    function automatic int num_stages(input int num);
        int l;
        l = log2_int(num);
        return l * (l + 1) / 2;
    endfunction

    localparam int DEFAULT_NUM = 16;
    localparam int DEFAULT_W   = 16;
    localparam int NET_L       = log2_int(DEFAULT_NUM);
    localparam int NET_S       = num_stages(DEFAULT_NUM);

    typedef logic [DEFAULT_W-1:0] key_t;

endpackage

// File: rtl/bitonic_cmp_swap.sv
// Single compare-exchange element of the bitonic network.
// Ports:
//   a, b    : keys on the lower and upper lane of the pair (unsigned)
//   asc     : 1 = lower lane receives the minimum, 0 = lower lane receives the maximum
//   lo_out  : key for the lower lane
//   hi_out  : key for the upper lane
// Purely combinational; equal keys pass straight through.
module bitonic_cmp_swap #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         asc,
    output logic [W-1:0] lo_out,
    output logic [W-1:0] hi_out
);

    logic swap;

    // Strict comparisons so equal keys never swap.
    assign swap   = asc ? (a > b) : (a < b);
    assign lo_out = swap ? b : a;
    assign hi_out = swap ? a : b;

endmodule

// File: rtl/bitonic_network.sv
// Fully pipelined bitonic sorting network.
// Sorts NUM unsigned W-bit keys each cycle; one register bank follows every
// compare-exchange stage, so a vector sampled with in_valid at edge n is
// registered at edges n .. n+S-1 and is presented on OUT/out_valid for
// capture by the consumer at edge n+S.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   in_valid   : IN and direction qualify this cycle
//   direction  : 0 = ascending (lane 0 smallest), 1 = descending
//   IN         : unsorted keys, lane i = IN[i*W +: W]
//   out_valid  : OUT holds a sorted vector
//   OUT        : sorted keys, lane i = OUT[i*W +: W]
module bitonic_network
    import bitonic_network_pkg::*;
#(
    parameter int NUM = DEFAULT_NUM,
    parameter int W   = DEFAULT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic           direction,
    input  logic [NUM*W-1:0] IN,
    output logic           out_valid,
    output logic [NUM*W-1:0] OUT
);

    localparam int L = log2_int(NUM);
    localparam int S = num_stages(NUM);

    logic [W-1:0] stin [S][NUM];   // input of each compare-exchange stage
    logic [W-1:0] cx   [S][NUM];   // combinational result of each stage
    logic [W-1:0] pipe [S][NUM];   // register bank after each stage
    logic [S-1:0] vld_q;
    logic [S-1:0] dir_q;
    logic [S-1:0] stdir;           // direction seen by each stage

    // Stage 0 works on the raw input; every later stage on the previous bank.
    always_comb begin
        // NOTE: every element is assigned on every pass through this block, so no latch is inferred.
        stdir[0] = direction;
        for (int i = 0; i < NUM; i++) stin[0][i] = IN[i*W +: W];
        for (int s = 1; s < S; s++) begin
            stdir[s] = dir_q[s-1];
            for (int i = 0; i < NUM; i++) stin[s][i] = pipe[s-1][i];
        end
    end

    // Phase p merges blocks of K = 2^p; within it, distances J = K/2 .. 1.
    for (genvar p = 1; p <= L; p++) begin : g_phase
        for (genvar r = 0; r < p; r++) begin : g_dist
            localparam int SI = p * (p - 1) / 2 + r;
            localparam int K  = 1 << p;
            localparam int J  = 1 << (p - 1 - r);
            for (genvar i = 0; i < NUM; i++) begin : g_lane
                if ((i & J) == 0) begin : g_pair
                    // Pair order before the per-vector direction flip.
                    localparam bit BASE_ASC = ((i & K) == 0);
                    bitonic_cmp_swap #(.W(W)) u_cx (
                        .a      (stin[SI][i]),
                        .b      (stin[SI][i+J]),
                        .asc    (stdir[SI] ^ BASE_ASC),
                        .lo_out (cx[SI][i]),
                        .hi_out (cx[SI][i+J])
                    );
                end
            end
        end
    end

    // Data, direction and valid move in lockstep; data loads regardless of valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data banks are cleared on reset as well, so OUT reads zero immediately.
            for (int s = 0; s < S; s++)
                for (int i = 0; i < NUM; i++) pipe[s][i] <= '0;
            vld_q <= '0;
            dir_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every bank sample its predecessor's old value.
            for (int s = 0; s < S; s++)
                for (int i = 0; i < NUM; i++) pipe[s][i] <= cx[s][i];
            vld_q[0] <= in_valid;
            dir_q[0] <= direction;
            for (int s = 1; s < S; s++) begin
                vld_q[s] <= vld_q[s-1];
                dir_q[s] <= dir_q[s-1];
            end
        end
    end

    for (genvar i = 0; i < NUM; i++) begin : g_out
        assign OUT[i*W +: W] = pipe[S-1][i];
    end
    assign out_valid = vld_q[S-1];

endmodule

// File: tb/tb_bitonic_network.sv
// Self-checking bench for bitonic_network (NUM=16, W=16, S=10).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// A vector driven at falling edge c is sampled at the next rising edge and is
// expected on OUT at falling edge c+S.
module tb_bitonic_network;
    import bitonic_network_pkg::*;

    localparam int NUM = 16;
    localparam int W   = 16;
    localparam int S   = 10;
    localparam int NB  = 200;

    typedef logic [NUM*W-1:0] vec_t;

    logic clk;
    logic rst_n;
    logic in_valid;
    logic direction;
    vec_t in_bus;
    logic out_valid;
    vec_t out_bus;

    int passed;
    int total;

    vec_t bb_v [NB];
    logic bb_d [NB];

    bitonic_network #(.NUM(NUM), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .direction (direction),
        .IN        (in_bus),
        .out_valid (out_valid),
        .OUT       (out_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference sort (bubble sort) used to build expected vectors.
    function automatic vec_t ref_sort(input vec_t v, input logic d);
        key_t a [NUM];
        key_t t;
        vec_t r;
        for (int i = 0; i < NUM; i++) a[i] = v[i*W +: W];
        for (int x = 0; x < NUM; x++) begin
            for (int y = 0; y < NUM - 1 - x; y++) begin
                if (d ? (a[y] < a[y+1]) : (a[y] > a[y+1])) begin
                    t      = a[y];
                    a[y]   = a[y+1];
                    a[y+1] = t;
                end
            end
        end
        r = '0;
        for (int i = 0; i < NUM; i++) r[i*W +: W] = a[i];
        return r;
    endfunction

    function automatic vec_t fill(input key_t k);
        vec_t r;
        r = '0;
        for (int i = 0; i < NUM; i++) r[i*W +: W] = k;
        return r;
    endfunction

    // One valid vector, then idle: out_valid must pulse exactly once, S cycles later.
    task automatic run_single(input string name, input vec_t v, input logic d, input vec_t exp);
        @(negedge clk);
        in_valid  = 1'b1;
        direction = d;
        in_bus    = v;
        for (int c = 1; c <= S + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                in_valid  = 1'b0;
                direction = 1'b0;
                in_bus    = '0;
            end
            total++;
            if (out_valid !== (c == S)) begin
                $display("FAIL %s valid c=%0d: got %b expected %b", name, c, out_valid, (c == S));
            end else passed++;
            if (c == S) begin
                total++;
                if (out_bus !== exp) $display("FAIL %s data: got %h expected %h", name, out_bus, exp);
                else passed++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        direction = 1'b0;
        in_bus    = fill(16'h1234);
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0) $display("FAIL reset valid: got %b expected 0", out_valid);
        else passed++;
        total++;
        if (out_bus !== '0) $display("FAIL reset data: got %h expected 0", out_bus);
        else passed++;
        in_valid = 1'b0;
        in_bus   = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (S + 1) @(negedge clk);
        total++;
        if (out_valid !== 1'b0) $display("FAIL idle valid: got %b expected 0", out_valid);
        else passed++;
    endtask

    task automatic test_reversed_asc();
        vec_t v, e;
        for (int i = 0; i < NUM; i++) begin
            v[i*W +: W] = key_t'(15 - i);
            e[i*W +: W] = key_t'(i);
        end
        run_single("rev_asc", v, 1'b0, e);
    endtask

    task automatic test_reversed_desc();
        vec_t v;
        for (int i = 0; i < NUM; i++) v[i*W +: W] = key_t'(15 - i);
        // Descending result of 15..0 is the same list.
        run_single("rev_desc", v, 1'b1, v);
    endtask

    task automatic test_duplicates();
        vec_t v, e;
        v = fill(16'h7FFF);
        v[0*W +: W] = 16'hFFFF;
        v[1*W +: W] = 16'h0000;
        v[2*W +: W] = 16'h8000;
        v[3*W +: W] = 16'h8000;
        v[4*W +: W] = 16'h0001;
        e = fill(16'h7FFF);
        e[0*W +: W]  = 16'h0000;
        e[1*W +: W]  = 16'h0001;
        e[13*W +: W] = 16'h8000;
        e[14*W +: W] = 16'h8000;
        e[15*W +: W] = 16'hFFFF;
        run_single("dups", v, 1'b0, e);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rnd;
        for (int n = 0; n < NB; n++) begin
            for (int i = 0; i < NUM; i++) begin
                rnd = $urandom;
                bb_v[n][i*W +: W] = (n % 4 == 0) ? {14'b0, rnd[1:0]} : rnd[15:0];
            end
            rnd     = $urandom;
            bb_d[n] = rnd[0];
        end
        for (int c = 0; c < NB + S; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== (c >= S)) $display("FAIL b2b valid c=%0d: got %b expected %b", c, out_valid, (c >= S));
            else passed++;
            if (c >= S) begin
                total++;
                if (out_bus !== ref_sort(bb_v[c-S], bb_d[c-S]))
                    $display("FAIL b2b data n=%0d: got %h expected %h", c - S, out_bus, ref_sort(bb_v[c-S], bb_d[c-S]));
                else passed++;
                total++;
                if (ref_sort(out_bus, 1'b0) !== ref_sort(bb_v[c-S], 1'b0))
                    $display("FAIL b2b perm n=%0d: got %h expected %h", c - S, ref_sort(out_bus, 1'b0), ref_sort(bb_v[c-S], 1'b0));
                else passed++;
            end
            if (c < NB) begin
                in_valid  = 1'b1;
                direction = bb_d[c];
                in_bus    = bb_v[c];
            end else begin
                in_valid  = 1'b0;
                direction = 1'b0;
                in_bus    = '0;
            end
        end
    endtask

    task automatic test_valid_gaps();
        logic [3:0] pat;
        vec_t gv [4];
        logic exp_v;
        pat = 4'b1001;
        for (int n = 0; n < 4; n++)
            for (int i = 0; i < NUM; i++) gv[n][i*W +: W] = key_t'((i * 7 + n * 3) % 16);
        for (int c = 0; c < S + 5; c++) begin
            @(negedge clk);
            exp_v = (c >= S && c - S < 4) ? pat[c - S] : 1'b0;
            total++;
            if (out_valid !== exp_v) $display("FAIL gaps valid c=%0d: got %b expected %b", c, out_valid, exp_v);
            else passed++;
            if (exp_v) begin
                total++;
                if (out_bus !== ref_sort(gv[c-S], 1'b0))
                    $display("FAIL gaps data c=%0d: got %h expected %h", c, out_bus, ref_sort(gv[c-S], 1'b0));
                else passed++;
            end
            if (c < 4) begin
                in_valid = pat[c];
                in_bus   = gv[c];
            end else begin
                in_valid = 1'b0;
                in_bus   = '0;
            end
            direction = 1'b0;
        end
    endtask

    task automatic test_reset_midflight();
        // Fill the pipe so out_valid is high, then reset between clock edges.
        for (int c = 0; c < S + 6; c++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            direction = c[0];
            in_bus    = fill(key_t'(c + 1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_bus   = '0;
        repeat (4) @(posedge clk);
        #2;
        total++;
        if (out_valid !== 1'b1) $display("FAIL midflight pre valid: got %b expected 1", out_valid);
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL midflight rst valid: got %b expected 0", out_valid);
        else passed++;
        total++;
        if (out_bus !== '0) $display("FAIL midflight rst data: got %h expected 0", out_bus);
        else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= S + 3; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) $display("FAIL midflight ghost c=%0d: got %b expected 0", c, out_valid);
            else passed++;
        end
    endtask

    task automatic test_after_reset();
        vec_t v, e;
        for (int i = 0; i < NUM; i++) begin
            v[i*W +: W] = key_t'((i * 5) % 16);
            e[i*W +: W] = key_t'(15 - i);
        end
        run_single("post_reset", v, 1'b1, e);
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        direction = 1'b0;
        in_bus    = '0;
        test_reset();
        test_reversed_asc();
        test_reversed_desc();
        test_duplicates();
        test_back_to_back();
        test_valid_gaps();
        test_reset_midflight();
        test_after_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bitonic_network.md
Name: bitonic_network

Overview:
- Fully pipelined bitonic sorting network. Sorts NUM unsigned W-bit keys presented in parallel on one flat bus; a new vector can be accepted every cycle.
- Sits in the RTHS datapath wherever a parallel sort or merge of key vectors is needed.
- Sort direction is selectable per vector and travels with the data.

Parameters:
- NUM, 16, number of keys; power of two, 2..64.
- W, 16, key width in bits; keys compared as unsigned.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  IN and direction qualify this cycle.
- direction  input  1  0 = ascending (lane 0 smallest), 1 = descending (lane 0 largest).
- IN  input  NUM*W  unsorted keys; lane i = IN[i*W +: W].
- out_valid  output  1  OUT holds a sorted vector.
- OUT  output  NUM*W  sorted keys; lane i = OUT[i*W +: W].

Behaviour:
- Stage count S = L*(L+1)/2, where L = log2(NUM); S = 10 for NUM=16.
- Network structure: standard bitonic sort.
  - For block size k = 2, 4, ..., NUM, and distance j = k/2 down to 1: lane i is compare-exchanged with lane i^j, for i with bit j clear.
  - Pair order is ascending when (i & k) == 0, else descending. This applies for direction=0.
  - direction=1 inverts every pair order.
- Compare-exchange: for an ascending pair, the lower lane gets min and the upper lane gets max. Descending is the reverse. Equal keys are not swapped.
- Pipeline:
  - One register bank after every compare-exchange stage. Data, direction and valid advance together each cycle.
  - No stall, no backpressure.
  - Latency from in_valid sampled at edge n to out_valid at edge n+S is exactly S cycles. Throughput is one vector per cycle.
- Vectors with in_valid=0 still propagate (data don't-care) but emerge with out_valid=0. Data registers may load unconditionally.
- Each vector uses its own direction bit; adjacent vectors with different directions are both sorted correctly.
- Reset (rst_n low, asynchronous):
  - All valid bits, all data registers and OUT go to 0 immediately.
  - Vectors in flight are discarded.
  - After release, the first in_valid sampled produces out_valid S cycles later.
- Combinational behaviour: no path from IN to OUT; OUT and out_valid come directly from registers.
- OUT is a permutation of the accepted IN (multiset preserved), sorted per direction.

Decomposition:
- Shared package, holding:
  - the function computing S from NUM;
  - localparams for L and S;
  - a key typedef of width W, if the codebase's package style allows parameterized widths.
- Sub-module: bitonic_cmp_swap.
  - Inputs: a, b, asc.
  - Outputs: lo_out, hi_out.
  - Purely combinational unsigned compare with swap; no swap on equality.
- Top level: generate loops over k, j and pair index instantiating bitonic_cmp_swap, plus per-stage registers with valid/direction shift.

Test Plan:
- Reversed input, ascending: NUM=16, W=16, IN lanes 0..15 = 15,14,...,0, direction=0, in_valid=1 for one cycle. Required: out_valid high exactly 10 cycles later, OUT lanes 0..15 = 0,1,...,15.
- Same input, descending: IN lanes 0..15 = 15,...,0, direction=1. Required: OUT lanes = 15,...,0 after 10 cycles.
- Duplicates and extremes: lanes = 0xFFFF, 0x0000, 0x8000, 0x8000, 0x0001, then 11 lanes of 0x7FFF, direction=0. Required: OUT = 0x0000, 0x0001, eleven lanes of 0x7FFF, 0x8000, 0x8000, 0xFFFF; confirms unsigned compare.
- Back-to-back streaming: 200 consecutive random vectors with random direction and in_valid always 1. Required:
  - out_valid continuously high from cycle 10;
  - each output equals a reference sort of the vector accepted 10 cycles earlier, in that vector's direction;
  - each output is a permutation of that input.
- Valid gaps: in_valid pattern 1,0,0,1. Required: out_valid pattern 1,0,0,1 delayed by 10 cycles.
- Reset mid-flight: assert rst_n=0 asynchronously, between clock edges, 4 cycles after a valid input. Required:
  - out_valid and OUT go to 0 immediately;
  - no out_valid pulse appears for the discarded vector after rst_n is released.
